input_debouncer: RTL
====================

Name: input_debouncer

Overview:
- Upstream conditioning stage for the edge detector. Takes a raw, asynchronous, possibly bouncing 1-bit input (button, switch, external strobe).
- Synchronises the input into the clk domain, then filters it with a stability counter. Emits a clean registered level that drives the edge detector's `in` directly.
- Also reports filter activity (busy) and counts rejected glitches for debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range ≥2.
- STABLE_CYCLES, 4, consecutive synchronised cycles at the new level required before db_out changes; legal range ≥1.
- GLITCH_W, 8, width of the saturating glitch counter.
- CNT_W (localparam), max(1, clog2(STABLE_CYCLES)), stability counter width; not overridable.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- in  input  1  raw asynchronous input.
- db_out  output  1  debounced level; registered; feeds edge detector `in`.
- busy  output  1  high while a level change is being qualified (state CHK_HI or CHK_LO).
- glitch_count  output  GLITCH_W  number of aborted qualifications; saturates at all-ones.

Behaviour:
- Reset values: all sync flops 0, state LOW, stability counter 0, db_out 0, busy 0, glitch_count 0. rst wins over every other event in the same cycle.
- Reset mid-qualification returns to LOW and clears all counts. No partial state survives.
- Synchroniser: a SYNC_STAGES-deep shift chain clocked by clk. in_sync is the last stage. No logic between stages.
- FSM states: LOW, CHK_HI, HIGH, CHK_LO. Encoding is in the package.
- LOW:
  - in_sync=1 → CHK_HI, cnt←0.
  - Otherwise stay.
- CHK_HI:
  - in_sync=1 and cnt==STABLE_CYCLES-1 → HIGH.
  - in_sync=1 otherwise → cnt←cnt+1.
  - in_sync=0 → LOW, cnt←0, glitch_count←glitch_count+1 unless already all-ones.
- HIGH and CHK_LO: exact mirror of LOW and CHK_HI with polarity inverted. An abort from CHK_LO returns to HIGH and also increments glitch_count.
- Outputs are Moore and registered from state:
  - db_out=1 in HIGH and CHK_LO; 0 in LOW and CHK_HI.
  - busy=1 in CHK_HI and CHK_LO.
- Latency: a clean step on in (setup-met before edge 1) makes db_out change after edge SYNC_STAGES+1+STABLE_CYCLES. Defaults give 7 edges.
- Counter never exceeds STABLE_CYCLES-1. With STABLE_CYCLES=1, the qualifying state lasts exactly one cycle.
- A glitch is any return to the original level before qualification completes, including a 1-cycle pulse on in_sync. Each glitch increments glitch_count by exactly 1.
- glitch_count at all-ones holds; it does not wrap.
- db_out never toggles more than once per STABLE_CYCLES+1 cycles, so the edge detector sees at most one edge per qualified transition.

Decomposition:
- Shared package holds:
  - FSM state localparams (LOW=2'd0, CHK_HI=2'd1, HIGH=2'd2, CHK_LO=2'd3).
  - The default SYNC_STAGES and STABLE_CYCLES constants, reused by the top-level integration.
- One sub-module, sync_chain: a parameterised DEPTH-flop synchroniser with synchronous active-high reset to 0. Reusable for other async inputs.
- FSM, counter and glitch counter stay in input_debouncer.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in=1 → db_out=0, busy=0, glitch_count=0 throughout. After release, db_out rises exactly 7 edges later (defaults).
- Clean rise then fall: in 0→1, held 20 cycles, then 1→0 → db_out rises 7 edges after the rise and falls 7 edges after the fall. busy is high for exactly 4 cycles before each change. glitch_count stays 0.
- Glitch rejection: with db_out=0, pulse in high for 2 cycles → db_out stays 0, busy high for 2 cycles, glitch_count=1. A 1-cycle pulse → glitch_count=2.
- Bounce burst: in toggles 1,0,1,0,1 each cycle, then holds 1 → db_out rises once, 7 edges after the final rising transition. glitch_count=2. The downstream edge detector emits exactly one riseedge.
- Saturation: GLITCH_W=2 with 5 isolated 1-cycle pulses → glitch_count reads 1,2,3,3,3.
- Reset mid-qualification: assert rst while busy=1 in CHK_HI (cnt=2) → next edge shows state LOW, db_out=0, busy=0, glitch_count=0. With in still 1 after release, db_out rises 7 edges after release.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer_pkg
//  Description : Shared constants for the input debouncer: FSM state
//                encoding and the default synchroniser / stability settings
//                reused by top-level integration.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

    // Filter FSM state encoding
    localparam logic [1:0] LOW    = 2'd0;
    localparam logic [1:0] CHK_HI = 2'd1;
    localparam logic [1:0] HIGH   = 2'd2;
    localparam logic [1:0] CHK_LO = 2'd3;

    // Default configuration shared with the integration level
    localparam int c_default_sync_stages   = 2;
    localparam int c_default_stable_cycles = 4;

endpackage
`default_nettype wire

// File: rtl/input_debouncer_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : DEPTH-flop synchroniser for a single asynchronous bit.
//                Plain shift chain, no logic between stages, synchronous
//                active-high reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_stages;

    // Shift the raw input through the chain; the oldest stage is the output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[DEPTH-2:0], d};
        end
    end

    assign q = r_stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Synchronises a raw asynchronous input, then qualifies each
//                level change with a stability counter. Produces a clean
//                registered level, a busy flag while a change is being
//                qualified and a saturating count of aborted qualifications.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = c_default_sync_stages,
    parameter int STABLE_CYCLES = c_default_stable_cycles,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    output logic                db_out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    c_cnt_last   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] c_glitch_max = '1;

    logic                w_in_sync;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [GLITCH_W-1:0] r_glitch;
    logic [GLITCH_W-1:0] w_glitch_nxt;
    logic [GLITCH_W-1:0] w_glitch_inc;
    logic                r_db;
    logic                r_busy;

    sync_chain #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (w_in_sync)
    );

    // Saturating increment: all-ones holds instead of wrapping
    assign w_glitch_inc = (r_glitch == c_glitch_max) ? r_glitch
                                                     : r_glitch + GLITCH_W'(1);

    // Next-state logic: qualify a new level, abort back on any early return
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_glitch_nxt = r_glitch;
        case (r_state)
            LOW: begin
                if (w_in_sync) begin
                    w_state_nxt = CHK_HI;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_HI: begin
                if (w_in_sync) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt  = LOW;
                    w_cnt_nxt    = '0;
                    w_glitch_nxt = w_glitch_inc;
                end
            end
            HIGH: begin
                if (!w_in_sync) begin
                    w_state_nxt = CHK_LO;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_LO: begin
                if (!w_in_sync) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt  = HIGH;
                    w_cnt_nxt    = '0;
                    w_glitch_nxt = w_glitch_inc;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counters and Moore outputs registered together from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOW;
            r_cnt    <= '0;
            r_glitch <= '0;
            r_db     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_glitch <= w_glitch_nxt;
            r_db     <= (w_state_nxt == HIGH) || (w_state_nxt == CHK_LO);
            r_busy   <= (w_state_nxt == CHK_HI) || (w_state_nxt == CHK_LO);
        end
    end

    assign db_out       = r_db;
    assign busy         = r_busy;
    assign glitch_count = r_glitch;

endmodule
`default_nettype wire
